// File: rtl/jtag_tap_sampled_pkg.sv
// Shared TAP definitions: state codes, instruction codes, IR capture pattern, next-state table.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package jtag_tap_sampled_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR_SCAN   = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR_SCAN   = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_t;

    localparam logic [3:0] IDCODE_INSN     = 4'b0001;
    localparam logic [3:0] BYPASS_INSN     = 4'b1111;
    // Low two bits loaded into the IR shifter in Capture-IR; upper bits are zero.
    localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

    // Standard 1149.1 TMS-driven next-state table.
    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        case (s)
            TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   n = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       n = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         n = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         n = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         n = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         n = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       n = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         n = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         n = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         n = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         n = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          n = TEST_LOGIC_RESET;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_pin_sync.sv
// Pin synchroniser: STAGES flops into clk, one history flop, rise/fall strobes.
// Latency: sync follows the pin after STAGES clk; rise/fall strobe in that same cycle.
// Backpressure: none; free-running sampler.
module jtag_pin_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // Metastability chain plus one-cycle history of the synchronised level.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], pin};
            prev  <= chain[STAGES-1];
        end
    end

    assign sync = chain[STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/jtag_tap_sampled.sv
// Oversampled 1149.1 TAP (IDCODE + BYPASS); optional TRST_N pin via JTAG_TRST_EN.
// Latency: TAP acts SYNC_STAGES+1 clk after a TCK pin edge; TDO/OE update on the TCK fall.
// Backpressure: none; pin-driven, every detected TCK edge is consumed.
module jtag_tap_sampled
    import jtag_tap_sampled_pkg::*;
#(
    parameter logic [31:0] IDCODE      = 32'h149511C3,
    parameter int          IR_WIDTH    = 4,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tck_i,
    input  logic                tms_i,
    input  logic                tdi_i,
`ifdef JTAG_TRST_EN
    input  logic                trst_n_i,
`endif
    output logic                tdo_o,
    output logic                tdo_oe_o,
    output logic [3:0]          tap_state_o,
    output logic [IR_WIDTH-1:0] ir_o
);

    localparam logic [IR_WIDTH-1:0] INSN_IDCODE = IR_WIDTH'(IDCODE_INSN);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE  = IR_WIDTH'(IR_CAPTURE_LSBS);

    logic tck_sync, tck_rise, tck_fall;
    logic tms_sync, tms_rise, tms_fall;
    logic tdi_sync, tdi_rise, tdi_fall;
    logic tck_fall_ok;
    logic trst_active;

    jtag_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_tck (
        .clk(clk), .rst(rst), .pin(tck_i), .sync(tck_sync), .rise(tck_rise), .fall(tck_fall));
    jtag_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_tms (
        .clk(clk), .rst(rst), .pin(tms_i), .sync(tms_sync), .rise(tms_rise), .fall(tms_fall));
    jtag_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_tdi (
        .clk(clk), .rst(rst), .pin(tdi_i), .sync(tdi_sync), .rise(tdi_rise), .fall(tdi_fall));

`ifdef JTAG_TRST_EN
    logic trst_sync, trst_rise, trst_fall;
    jtag_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_trst (
        .clk(clk), .rst(rst), .pin(trst_n_i), .sync(trst_sync), .rise(trst_rise), .fall(trst_fall));
    assign trst_active = ~trst_sync;
    logic unused_trst_edges;
    assign unused_trst_edges = trst_rise ^ trst_fall;
`else
    assign trst_active = 1'b0;
`endif

    // Only the TCK strobes and the TMS/TDI levels are consumed.
    logic unused_pin_bits;
    assign unused_pin_bits = ^{tck_sync, tms_rise, tms_fall, tdi_rise, tdi_fall};

    // A glitched history can never assert both, but rise wins if it ever did.
    assign tck_fall_ok = tck_fall & ~tck_rise;

    tap_state_t              state_q, state_d;
    logic [IR_WIDTH-1:0]     ir_q, ir_shift;
    logic [31:0]             dr_shift;
    logic                    bypass_q;
    logic                    sel_idcode;
    logic                    ir_path;
    logic                    tdo_next;

    // TAP state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= TEST_LOGIC_RESET;
        else     state_q <= state_d;
    end

    // Next state: TRST holds reset, otherwise advance once per TCK rise.
    always_comb begin
        state_d = state_q;
        if (trst_active)   state_d = TEST_LOGIC_RESET;
        else if (tck_rise) state_d = tap_next(state_q, tms_sync);
    end

    assign sel_idcode = (ir_q == INSN_IDCODE);
    assign ir_path    = (state_q == CAPTURE_IR) || (state_q == SHIFT_IR) || (state_q == EXIT1_IR) ||
                        (state_q == PAUSE_IR)   || (state_q == EXIT2_IR) || (state_q == UPDATE_IR);
    assign tdo_next   = ir_path ? ir_shift[0] : (sel_idcode ? dr_shift[0] : bypass_q);

    // Capture/shift on TCK rise; TDO, OE and IR update on TCK fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q     <= INSN_IDCODE;
            ir_shift <= '0;
            dr_shift <= '0;
            bypass_q <= 1'b0;
            tdo_o    <= 1'b0;
            tdo_oe_o <= 1'b0;
        end else if (trst_active) begin
            ir_q     <= INSN_IDCODE;
            tdo_oe_o <= 1'b0;
        end else if (tck_rise) begin
            case (state_q)
                CAPTURE_IR: ir_shift <= IR_CAPTURE;
                SHIFT_IR:   ir_shift <= {tdi_sync, ir_shift[IR_WIDTH-1:1]};
                CAPTURE_DR: begin
                    if (sel_idcode) dr_shift <= IDCODE;
                    else            bypass_q <= 1'b0;
                end
                SHIFT_DR: begin
                    if (sel_idcode) dr_shift <= {tdi_sync, dr_shift[31:1]};
                    else            bypass_q <= tdi_sync;
                end
                default: ;
            endcase
            if (state_d == TEST_LOGIC_RESET) ir_q <= INSN_IDCODE;
        end else if (tck_fall_ok) begin
            tdo_o    <= tdo_next;
            tdo_oe_o <= (state_q == SHIFT_IR) || (state_q == SHIFT_DR);
            if (state_q == UPDATE_IR) ir_q <= ir_shift;
        end
    end

    assign tap_state_o = state_q;
    assign ir_o        = ir_q;

endmodule

// File: tb/tb_jtag_tap_sampled.sv
module tb_jtag_tap_sampled;

    logic       clk = 1'b0;
    logic       rst, tck, tms, tdi;
`ifdef JTAG_TRST_EN
    logic       trst_n;
`endif
    logic       tdo, tdo_oe;
    logic [3:0] tap_state;
    logic [3:0] ir;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [31:0] EXP_IDCODE = 32'h149511C3;

    typedef struct {
        logic       tms;
        logic       tdi;
        logic [3:0] st;
        logic       oe;
        logic [3:0] irv;
        logic       chk_tdo;
        logic       tdo;
    } vec_t;

    vec_t vecs [22];

    always #5 clk = ~clk;

    jtag_tap_sampled dut (
        .clk        (clk),
        .rst        (rst),
        .tck_i      (tck),
        .tms_i      (tms),
        .tdi_i      (tdi),
`ifdef JTAG_TRST_EN
        .trst_n_i   (trst_n),
`endif
        .tdo_o      (tdo),
        .tdo_oe_o   (tdo_oe),
        .tap_state_o(tap_state),
        .ir_o       (ir)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // One full TCK period; returns TDO as it stands after the falling edge.
    task automatic tck_cycle(input logic t_ms, input logic t_di, output logic tdo_s);
        @(negedge clk);
        tms = t_ms;
        tdi = t_di;
        repeat (2) @(negedge clk);
        tck = 1'b1;
        repeat (6) @(negedge clk);
        tck = 1'b0;
        repeat (6) @(negedge clk);
        tdo_s = tdo;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        s;
        logic [31:0] word;
        logic [3:0]  nib;
        logic [3:0]  byp;

        rst = 1'b0; tck = 1'b0; tms = 1'b1; tdi = 1'b0;
`ifdef JTAG_TRST_EN
        trst_n = 1'b1;
`endif
        word = '0; nib = '0; byp = '0;

        //            tms   tdi   state oe    ir     chk   tdo
        vecs[0]  = '{1'b0, 1'b0, 4'hC, 1'b0, 4'h1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 4'h7, 1'b0, 4'h1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 4'h6, 1'b0, 4'h1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 4'h2, 1'b1, 4'h1, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 4'h3, 1'b0, 4'h1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 4'h0, 1'b0, 4'h1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 4'h2, 1'b1, 4'h1, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 4'h1, 1'b0, 4'h1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 4'h5, 1'b0, 4'h1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 4'h7, 1'b0, 4'h1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 4'h4, 1'b0, 4'h1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 4'hE, 1'b0, 4'h1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 4'hA, 1'b1, 4'h1, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 4'h9, 1'b0, 4'h1, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 4'hB, 1'b0, 4'h1, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 4'h8, 1'b0, 4'h1, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 4'hD, 1'b0, 4'h8, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 4'hC, 1'b0, 4'h8, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 4'h7, 1'b0, 4'h8, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 4'h4, 1'b0, 4'h8, 1'b0, 1'b0};
        vecs[21] = '{1'b1, 1'b0, 4'hF, 1'b0, 4'h1, 1'b0, 1'b0};

        // Reset for two clocks.
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset state",  32'(tap_state), 32'hF);
        check("reset ir",     32'(ir),        32'h1);
        check("reset tdo",    32'(tdo),       32'h0);
        check("reset tdo_oe", 32'(tdo_oe),    32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Walk through all 16 states.
        for (int i = 0; i < 22; i++) begin
            tck_cycle(vecs[i].tms, vecs[i].tdi, s);
            check($sformatf("vec%0d state", i), 32'(tap_state), 32'(vecs[i].st));
            check($sformatf("vec%0d tdo_oe", i), 32'(tdo_oe), 32'(vecs[i].oe));
            check($sformatf("vec%0d ir", i), 32'(ir), 32'(vecs[i].irv));
            if (vecs[i].chk_tdo)
                check($sformatf("vec%0d tdo", i), 32'(s), 32'(vecs[i].tdo));
        end

        // IDCODE read: TMS 0,1,0,0 then 31 more shifts, LSB first.
        tck_cycle(1'b0, 1'b0, s);
        tck_cycle(1'b1, 1'b0, s);
        tck_cycle(1'b0, 1'b0, s);
        tck_cycle(1'b0, 1'b0, s);
        word[0] = s;
        for (int i = 1; i < 32; i++) begin
            tck_cycle(1'b0, 1'b0, s);
            word[i] = s;
        end
        check("idcode word", word, EXP_IDCODE);
        tck_cycle(1'b1, 1'b0, s);
        check("idcode shifted-in zero", 32'(s), 32'h0);
        tck_cycle(1'b1, 1'b0, s);
        tck_cycle(1'b0, 1'b0, s);
        check("idcode back in idle", 32'(tap_state), 32'hC);

        // IR scan: shift in 1111, observe capture value.
        tck_cycle(1'b1, 1'b0, s);
        tck_cycle(1'b1, 1'b0, s);
        tck_cycle(1'b0, 1'b0, s);
        tck_cycle(1'b0, 1'b0, s);
        nib[0] = s;
        tck_cycle(1'b0, 1'b1, s); nib[1] = s;
        tck_cycle(1'b0, 1'b1, s); nib[2] = s;
        tck_cycle(1'b0, 1'b1, s); nib[3] = s;
        tck_cycle(1'b1, 1'b1, s);
        check("ir capture bits", 32'(nib), 32'h1);
        check("ir not yet updated", 32'(ir), 32'h1);
        tck_cycle(1'b1, 1'b0, s);
        check("ir after update", 32'(ir), 32'hF);
        tck_cycle(1'b0, 1'b0, s);
        check("ir scan idle state", 32'(tap_state), 32'hC);

        // BYPASS: TDI 1,0,1,1 gives TDO 0,1,0,1.
        tck_cycle(1'b1, 1'b0, s);
        tck_cycle(1'b0, 1'b0, s);
        tck_cycle(1'b0, 1'b0, s);
        byp[0] = s;
        check("bypass oe in shift", 32'(tdo_oe), 32'h1);
        tck_cycle(1'b0, 1'b1, s); byp[1] = s;
        tck_cycle(1'b0, 1'b0, s); byp[2] = s;
        tck_cycle(1'b0, 1'b1, s); byp[3] = s;
        tck_cycle(1'b0, 1'b1, s);
        check("bypass tdo stream", 32'(byp), 32'hA);
        check("bypass still shift-dr", 32'(tap_state), 32'h2);

        // Five TMS=1 edges from Shift-DR reach Test-Logic-Reset.
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, s);
        check("tms reset state", 32'(tap_state), 32'hF);
        check("tms reset ir", 32'(ir), 32'h1);
        check("tms reset tdo_oe", 32'(tdo_oe), 32'h0);

        // Reset 10 bits into an IR shift.
        tck_cycle(1'b0, 1'b0, s);
        tck_cycle(1'b1, 1'b0, s);
        tck_cycle(1'b1, 1'b0, s);
        tck_cycle(1'b0, 1'b0, s);
        tck_cycle(1'b0, 1'b0, s);
        for (int i = 0; i < 10; i++) tck_cycle(1'b0, 1'b1, s);
        check("mid-scan in shift-ir", 32'(tap_state), 32'hA);
        check("mid-scan oe", 32'(tdo_oe), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid-scan rst state", 32'(tap_state), 32'hF);
        check("mid-scan rst ir", 32'(ir), 32'h1);
        check("mid-scan rst oe", 32'(tdo_oe), 32'h0);
        check("mid-scan rst tdo", 32'(tdo), 32'h0);
        rst = 1'b0;
        tck_cycle(1'b1, 1'b0, s);
        check("after mid-scan state", 32'(tap_state), 32'hF);
        check("after mid-scan ir", 32'(ir), 32'h1);

`ifdef JTAG_TRST_EN
        // TRST low holds reset and ignores TCK.
        tck_cycle(1'b0, 1'b0, s);
        tck_cycle(1'b1, 1'b0, s);
        tck_cycle(1'b1, 1'b0, s);
        tck_cycle(1'b0, 1'b0, s);
        tck_cycle(1'b0, 1'b0, s);
        check("trst pre shift-ir", 32'(tap_state), 32'hA);
        @(negedge clk);
        trst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("trst state", 32'(tap_state), 32'hF);
        check("trst ir", 32'(ir), 32'h1);
        check("trst oe", 32'(tdo_oe), 32'h0);
        tms = 1'b0;
        tck = 1'b1;
        repeat (6) @(negedge clk);
        tck = 1'b0;
        repeat (6) @(negedge clk);
        check("trst ignores tck", 32'(tap_state), 32'hF);
        trst_n = 1'b1;
        repeat (4) @(negedge clk);
        tck_cycle(1'b0, 1'b0, s);
        check("trst released", 32'(tap_state), 32'hC);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
